// File: rtl/layer_compositor_if.sv
// rtl/layer_compositor_if.sv - video timing, layer and fade-command bundle for layer_compositor
interface layer_compositor_if #(
   parameter int NUM_LAYERS = 6,
   parameter int COLOR_W    = 12,
   parameter int CNT_W      = 11
);
   logic [CNT_W-1:0]            hcount_in;
   logic [CNT_W-1:0]            vcount_in;
   logic                        hsync_in;
   logic                        vsync_in;
   logic                        hblnk_in;
   logic                        vblnk_in;
   logic [COLOR_W-1:0]          bg_rgb_in;
   logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb_in;
   logic [NUM_LAYERS-1:0]       layer_opaque_in;
   logic [NUM_LAYERS-1:0]       layer_en_in;
   logic                        fade_out_req;
   logic                        fade_in_req;

   logic [CNT_W-1:0]            hcount_out;
   logic [CNT_W-1:0]            vcount_out;
   logic                        hsync_out;
   logic                        vsync_out;
   logic                        hblnk_out;
   logic                        vblnk_out;
   logic [COLOR_W-1:0]          rgb_out;
   logic                        frame_start;
   logic                        fade_done;
   logic [3:0]                  level_out;

   modport master (
      output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
      output bg_rgb_in, layer_rgb_in, layer_opaque_in, layer_en_in,
      output fade_out_req, fade_in_req,
      input  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
      input  rgb_out, frame_start, fade_done, level_out
   );

   modport slave (
      input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
      input  bg_rgb_in, layer_rgb_in, layer_opaque_in, layer_en_in,
      input  fade_out_req, fade_in_req,
      output hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
      output rgb_out, frame_start, fade_done, level_out
   );
endinterface

// File: rtl/layer_compositor.sv
// rtl/layer_compositor.sv - two-stage priority layer compositor with frame-stepped brightness fade
module layer_compositor #(
   parameter int NUM_LAYERS = 6,
   parameter int COLOR_W    = 12,
   parameter int CNT_W      = 11
) (
   input  logic              clk,
   input  logic              rst,
   layer_compositor_if.slave vid
);
   localparam int NUM_CH = COLOR_W / 4;

   localparam logic [1:0] ST_ON       = 2'd0;
   localparam logic [1:0] ST_FADE_OUT = 2'd1;
   localparam logic [1:0] ST_OFF      = 2'd2;
   localparam logic [1:0] ST_FADE_IN  = 2'd3;

   logic                  vsync_prev;
   logic                  frame_edge;
   logic [NUM_LAYERS-1:0] en_q;

   logic [1:0]            state;
   logic [1:0]            state_cmd;
   logic [1:0]            state_nxt;
   logic [3:0]            level;
   logic [3:0]            level_nxt;
   logic                  done_nxt;
   logic [4:0]            level_p1;

   logic [COLOR_W-1:0]    sel_rgb;
   logic [COLOR_W-1:0]    sel_rgb_q;
   logic [COLOR_W-1:0]    scaled_rgb;
   logic [CNT_W-1:0]      hcount_q;
   logic [CNT_W-1:0]      vcount_q;
   logic                  hsync_q;
   logic                  vsync_q;
   logic                  hblnk_q;
   logic                  vblnk_q;

   assign frame_edge    = vid.vsync_in & ~vsync_prev;
   assign vid.level_out = level;
   assign level_p1      = {1'b0, level} + 5'd1;

   // Frame boundary detection and the shadow enable mask it gates.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vsync_prev      <= 1'b0;
         vid.frame_start <= 1'b0;
         en_q            <= '0;
      end else begin
         vsync_prev      <= vid.vsync_in;
         vid.frame_start <= frame_edge;
         if (frame_edge) begin
            en_q <= vid.layer_en_in;
         end
      end
   end

   // Later layers override earlier ones, so the highest covering index wins.
   always_comb begin
      sel_rgb = vid.bg_rgb_in;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         if (en_q[i] && vid.layer_opaque_in[i]) begin
            sel_rgb = vid.layer_rgb_in[i*COLOR_W +: COLOR_W];
         end
      end
   end

   // Commands redirect the state immediately; the level only moves on a frame
   // edge, using the state after this cycle's command so a coincident command counts.
   always_comb begin
      state_cmd = state;
      if (vid.fade_out_req) begin
         if (state == ST_ON || state == ST_FADE_IN) begin
            state_cmd = ST_FADE_OUT;
         end
      end else if (vid.fade_in_req) begin
         if (state == ST_OFF || state == ST_FADE_OUT) begin
            state_cmd = ST_FADE_IN;
         end
      end

      state_nxt = state_cmd;
      level_nxt = level;
      done_nxt  = 1'b0;
      if (frame_edge) begin
         if (state_cmd == ST_FADE_OUT) begin
            level_nxt = (level == 4'd0) ? 4'd0 : level - 4'd1;
            if (level_nxt == 4'd0) begin
               state_nxt = ST_OFF;
               done_nxt  = 1'b1;
            end
         end else if (state_cmd == ST_FADE_IN) begin
            level_nxt = (level == 4'd15) ? 4'd15 : level + 4'd1;
            if (level_nxt == 4'd15) begin
               state_nxt = ST_ON;
               done_nxt  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= ST_ON;
         level         <= 4'd15;
         vid.fade_done <= 1'b0;
      end else begin
         state         <= state_nxt;
         level         <= level_nxt;
         vid.fade_done <= done_nxt;
      end
   end

   // Per-channel brightness: c*(level+1)/16, exact at level 15, zero at level 0.
   always_comb begin
      scaled_rgb = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         scaled_rgb[ch*4 +: 4] = 4'(({4'b0000, sel_rgb_q[ch*4 +: 4]} * {3'b000, level_p1}) >> 4);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hcount_q  <= '0;
         vcount_q  <= '0;
         hsync_q   <= 1'b0;
         vsync_q   <= 1'b0;
         hblnk_q   <= 1'b0;
         vblnk_q   <= 1'b0;
         sel_rgb_q <= '0;
      end else begin
         hcount_q  <= vid.hcount_in;
         vcount_q  <= vid.vcount_in;
         hsync_q   <= vid.hsync_in;
         vsync_q   <= vid.vsync_in;
         hblnk_q   <= vid.hblnk_in;
         vblnk_q   <= vid.vblnk_in;
         sel_rgb_q <= sel_rgb;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vid.hcount_out <= '0;
         vid.vcount_out <= '0;
         vid.hsync_out  <= 1'b0;
         vid.vsync_out  <= 1'b0;
         vid.hblnk_out  <= 1'b0;
         vid.vblnk_out  <= 1'b0;
         vid.rgb_out    <= '0;
      end else begin
         vid.hcount_out <= hcount_q;
         vid.vcount_out <= vcount_q;
         vid.hsync_out  <= hsync_q;
         vid.vsync_out  <= vsync_q;
         vid.hblnk_out  <= hblnk_q;
         vid.vblnk_out  <= vblnk_q;
         vid.rgb_out    <= (hblnk_q | vblnk_q) ? '0 : scaled_rgb;
      end
   end
endmodule

// File: doc/layer_compositor.md
LAYER_COMPOSITOR -- requirements
Module: layer_compositor

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 6, meaning the number of overlay layers (range 1..16).
REQ-002 SHALL have parameter COLOR_W, default 12, meaning the RGB word width, 4 bits per channel.
REQ-003 SHALL have parameter CNT_W, default 11, meaning the width of hcount/vcount.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with the ports clk and rst.
REQ-005 SHALL have the following ports (name  direction  width  meaning):
- clk  in  1  pixel clock (40 MHz)
- rst  in  1  async reset, active low
- hcount_in, vcount_in  in  CNT_W  pixel position
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1  timing signals
- bg_rgb_in  in  COLOR_W  background colour
- layer_rgb_in  in  NUM_LAYERS*COLOR_W  colour of layer i, slice [i*COLOR_W +: COLOR_W]
- layer_opaque_in  in  NUM_LAYERS  layer i covers this pixel
- layer_en_in  in  NUM_LAYERS  requested layer enables
- fade_out_req, fade_in_req  in  1  single-cycle fade commands
- hcount_out, vcount_out  out  CNT_W  delayed position
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1  delayed timing
- rgb_out  out  COLOR_W  composited pixel
- frame_start  out  1  one-cycle pulse at the frame boundary
- fade_done  out  1  one-cycle pulse when a fade completes
- level_out  out  4  current brightness level

Function
REQ-006 SHALL delay every timing output by exactly 2 clk cycles from the matching inputs, and SHALL keep rgb_out aligned to the same pixel.
REQ-007 SHALL define the frame boundary as a rising edge of vsync_in, detected with a registered previous value, and SHALL assert frame_start for exactly one cycle, in the cycle after that edge is seen.
REQ-008 SHALL hold a shadow register en_q that loads layer_en_in only at a frame boundary, so that mid-frame changes to layer_en_in have no effect until the next frame.
REQ-009 Stage 1 SHALL select the highest-index layer i with en_q[i]=1 and layer_opaque_in[i]=1; if no such layer exists it SHALL select bg_rgb_in.
REQ-010 Stage 2 SHALL scale each 4-bit channel c to (c*(level+1))>>4, with level 15 passing colours unchanged and level 0 giving (c>>4)=0.
REQ-011 SHALL force rgb_out to 0 in any cycle where hblnk_out or vblnk_out is 1.
REQ-012 SHALL implement the fade state machine with states ON (level=15), FADE_OUT, OFF (level=0), and FADE_IN.
REQ-013 The fade state machine SHALL make these transitions:
- ON + fade_out_req -> FADE_OUT
- OFF + fade_in_req -> FADE_IN
- FADE_OUT + fade_in_req -> FADE_IN
- FADE_IN + fade_out_req -> FADE_OUT
REQ-014 Reversing a fade SHALL continue from the current level and SHALL NOT restart it.
REQ-015 fade_out_req in state OFF and fade_in_req in state ON SHALL be ignored.
REQ-016 If fade_out_req and fade_in_req arrive in the same cycle, fade_out_req SHALL win.
REQ-017 Commands SHALL be latched on any cycle, but level SHALL change only at frame boundaries, by 1 per frame (FADE_OUT decrements, FADE_IN increments), so a full fade takes 15 frames.
REQ-018 On reaching level 0 in FADE_OUT the block SHALL enter OFF, and on reaching level 15 in FADE_IN it SHALL enter ON; each of these SHALL pulse fade_done for one cycle, in the same cycle as the last level update.
REQ-019 A fade command that coincides with a frame boundary SHALL take effect for that boundary's level step.
REQ-020 level_out SHALL equal the level register, and the level register SHALL saturate at 0 and 15 with no wrap-around.

Reset
REQ-021 While rst=0, all pipeline registers and outputs SHALL be 0, en_q SHALL be 0 (background only), state SHALL be ON, level SHALL be 15, and frame_start and fade_done SHALL be 0.
REQ-022 When rst is asserted mid-fade, the block SHALL return at once to ON/15, and any pending commands SHALL be discarded.
REQ-023 After release, the first frame_start SHALL require a rising edge of vsync_in observed after release, with the previous vsync value reset to 0.

Verification
REQ-024 Priority: NUM_LAYERS=6, en=6'b111111 loaded at a frame boundary, opaque=6'b000101, layer0=12'hF00, layer2=12'h0F0, bg=12'h00F, blanking low -> rgb_out=12'h0F0 exactly 2 cycles later.
REQ-025 Shadow enable: change layer_en_in from 6'b000100 to 6'b000000 mid-frame -> rgb_out stays 12'h0F0 until the next frame_start, then becomes 12'h00F.
REQ-026 Fade out: a fade_out_req pulse at level 15, then 15 frame boundaries -> level_out steps 14, 13, ... 0; fade_done pulses once at level 0; rgb_out from source 12'hFFF is 12'h000.
REQ-027 Reversal plus simultaneous commands: fade_in_req at level 9 in FADE_OUT -> level 10 at the next boundary; both requests high in the same cycle -> FADE_OUT is chosen.
REQ-028 Blanking and latency: hblnk_in=1 with an opaque layer at 12'hFFF -> rgb_out=0; hsync_out reproduces hsync_in shifted by exactly 2 cycles.
REQ-029 Reset mid-fade: rst=0 at level 5 during FADE_IN -> level_out=15, rgb_out=0 and no fade_done; after release and 2 vsync rising edges -> frame_start pulses twice.
